// File: rtl/thread_sched.sv
// thread_sched: per-cycle round-robin scheduler for 8 hardware thread contexts.
// Tracks FREE/INIT/READY/WAIT per thread, allocates threads on spawn and emits the
// one-cycle init writeback, applies kills and timed stalls, and registers one
// READY thread per cycle onto trd_dec.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   pipe_stall                     freezes issue_vld, trd_dec and the RR pointer
//   spawn_req/spawn_data           spawn request and initial context value
//   spawn_ack/spawn_trd            combinational spawn grant and allocated thread
//   kill_vld/kill_trd              terminate a thread (thread 0 ignored)
//   stall_vld/stall_trd/stall_cyc  park a READY thread for max(stall_cyc,1) cycles
//   issue_vld/trd_dec              registered decode pick
//   init_wb/new_trd_wb/init_data_wb  registered init pulse to the regfile set
//   trd_active                     bit i set when thread i is not FREE
//   no_free                        combinational; no FREE thread among 1..7
// Build option: define THREAD_SCHED_T0_PRIO_EN to give thread 0 every other slot.
module thread_sched #(
    parameter int NUM_TRD = 8,
    parameter int STALL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_stall,
    input  logic               spawn_req,
    input  logic [31:0]        spawn_data,
    output logic               spawn_ack,
    output logic [2:0]         spawn_trd,
    input  logic               kill_vld,
    input  logic [2:0]         kill_trd,
    input  logic               stall_vld,
    input  logic [2:0]         stall_trd,
    input  logic [STALL_W-1:0] stall_cyc,
    output logic               issue_vld,
    output logic [2:0]         trd_dec,
    output logic               init_wb,
    output logic [2:0]         new_trd_wb,
    output logic [31:0]        init_data_wb,
    output logic [NUM_TRD-1:0] trd_active,
    output logic               no_free
);
    typedef enum logic [1:0] {FREE, INIT, READY, WAIT} trd_state_e;

    trd_state_e         state_q [NUM_TRD];
    trd_state_e         state_d [NUM_TRD];
    logic [STALL_W-1:0] cnt_q   [NUM_TRD];
    logic [STALL_W-1:0] cnt_d   [NUM_TRD];
    logic [2:0]         ptr_q, ptr_d, trd_dec_q, trd_dec_d, new_trd_wb_q, new_trd_wb_d;
    logic [2:0]         spawn_idx, pick, idx;
    logic               issue_vld_q, issue_vld_d, init_wb_q, init_wb_d, found;
    logic [31:0]        init_data_wb_q, init_data_wb_d;
    logic [NUM_TRD-1:0] elig;

    // Lowest FREE thread in 1..7; index 0 doubles as "none free".
    always_comb begin
        spawn_idx = '0;
        for (int i = NUM_TRD - 1; i >= 1; i--)
            if (state_q[i] == FREE) spawn_idx = 3'(i);
        for (int i = 0; i < NUM_TRD; i++)
            trd_active[i] = state_q[i] != FREE;
        no_free   = spawn_idx == '0;
        spawn_ack = spawn_req & ~no_free;
        spawn_trd = spawn_ack ? spawn_idx : '0;
    end

    always_comb begin
        for (int i = 0; i < NUM_TRD; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                FREE:  if (spawn_ack && spawn_idx == 3'(i)) state_d[i] = INIT;
                INIT:  state_d[i] = READY;
                READY: if (stall_vld && stall_trd == 3'(i)) begin
                    state_d[i] = WAIT;
                    cnt_d[i]   = (stall_cyc == '0) ? STALL_W'(1) : stall_cyc;
                end
                WAIT: begin
                    cnt_d[i]   = cnt_q[i] - STALL_W'(1);
                    state_d[i] = (cnt_d[i] == '0) ? READY : WAIT;
                end
                default: state_d[i] = FREE;
            endcase
            // Kill overrides spawn and stall of the same thread.
            if (i != 0 && kill_vld && kill_trd == 3'(i)) begin
                state_d[i] = FREE;
                cnt_d[i]   = '0;
            end
            // Eligibility uses next state so the pick registered this cycle
            // already excludes threads stalled or killed now.
            elig[i] = state_d[i] == READY;
        end
    end

    always_comb begin
        found = 1'b0;
        pick  = trd_dec_q;
        idx   = '0;
        for (int k = 1; k <= NUM_TRD; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
`ifdef THREAD_SCHED_T0_PRIO_EN
        if (elig[0] && trd_dec_q != '0) begin
            pick  = '0;
            found = 1'b1;
        end
`else
`endif
        issue_vld_d    = pipe_stall ? issue_vld_q : found;
        trd_dec_d      = pipe_stall ? trd_dec_q : pick;
        ptr_d          = (pipe_stall || !found) ? ptr_q : pick;
        init_wb_d      = spawn_ack;
        new_trd_wb_d   = spawn_trd;
        init_data_wb_d = spawn_ack ? spawn_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= '{0: READY, default: FREE};
            cnt_q          <= '{default: '0};
            ptr_q          <= 3'd7;
            issue_vld_q    <= 1'b0;
            trd_dec_q      <= '0;
            init_wb_q      <= 1'b0;
            new_trd_wb_q   <= '0;
            init_data_wb_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            issue_vld_q    <= issue_vld_d;
            trd_dec_q      <= trd_dec_d;
            init_wb_q      <= init_wb_d;
            new_trd_wb_q   <= new_trd_wb_d;
            init_data_wb_q <= init_data_wb_d;
        end
    end

    assign issue_vld    = issue_vld_q;
    assign trd_dec      = trd_dec_q;
    assign init_wb      = init_wb_q;
    assign new_trd_wb   = new_trd_wb_q;
    assign init_data_wb = init_data_wb_q;
endmodule

// File: tb/tb_thread_sched.sv
// tb_thread_sched: randomized scoreboard bench for thread_sched against a timeline model.
module tb_thread_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_stall = 1'b0, spawn_req = 1'b0, kill_vld = 1'b0, stall_vld = 1'b0;
    logic [31:0] spawn_data = '0;
    logic [2:0]  kill_trd = '0, stall_trd = '0;
    logic [3:0]  stall_cyc = '0;
    logic        spawn_ack, issue_vld, init_wb, no_free;
    logic [2:0]  spawn_trd, trd_dec, new_trd_wb;
    logic [31:0] init_data_wb;
    logic [7:0]  trd_active;

    thread_sched dut (
        .clk(clk), .rst(rst), .pipe_stall(pipe_stall),
        .spawn_req(spawn_req), .spawn_data(spawn_data),
        .spawn_ack(spawn_ack), .spawn_trd(spawn_trd),
        .kill_vld(kill_vld), .kill_trd(kill_trd),
        .stall_vld(stall_vld), .stall_trd(stall_trd), .stall_cyc(stall_cyc),
        .issue_vld(issue_vld), .trd_dec(trd_dec),
        .init_wb(init_wb), .new_trd_wb(new_trd_wb), .init_data_wb(init_data_wb),
        .trd_active(trd_active), .no_free(no_free)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic vld; logic [2:0] trd;} iss_t;
    typedef struct packed {logic vld; logic [2:0] trd; logic [31:0] data;} ini_t;

    iss_t iss_q[$];
    ini_t ini_q[$];
    int   passed = 0, total = 0;
    bit   run = 1'b0;

    // Model: a thread is alive (allocated) and becomes issuable in slot rdy[t];
    // slot m is the trd_dec value visible during cycle m.
    bit         alive[8];
    int         rdy[8];
    int         ptr, n, ps_left;
    logic       exp_vld;
    logic [2:0] exp_trd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_init();
        for (int t = 0; t < 8; t++) begin
            alive[t] = (t == 0);
            rdy[t]   = 0;
        end
        ptr = 7; n = 0; ps_left = 0;
        exp_vld = 1'b0; exp_trd = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0;
        iss_q.delete(); ini_q.delete();
        pipe_stall = 0; spawn_req = 0; kill_vld = 0; stall_vld = 0;
        #1;
        chk("rst_issue_vld", issue_vld, 0);
        chk("rst_trd_dec", trd_dec, 0);
        chk("rst_init_wb", init_wb, 0);
        chk("rst_new_trd_wb", new_trd_wb, 0);
        chk("rst_init_data_wb", init_data_wb, 0);
        chk("rst_trd_active", trd_active, 8'h01);
        chk("rst_no_free", no_free, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_init();
        run = 1'b1;
    endtask

    task automatic step(input int kprob);
        int   ft, t;
        bit   ack, found;
        logic [7:0] act;
        iss_t ei;
        ini_t ii;
        spawn_req  = $urandom_range(0, 99) < 45;
        spawn_data = $urandom;
        kill_vld   = $urandom_range(0, 99) < kprob;
        kill_trd   = 3'($urandom_range(0, 7));
        stall_vld  = $urandom_range(0, 99) < 20;
        stall_trd  = 3'($urandom_range(0, 7));
        stall_cyc  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        if (ps_left == 0 && $urandom_range(0, 99) < 6) ps_left = $urandom_range(1, 4);
        pipe_stall = ps_left != 0;
        if (ps_left != 0) ps_left--;
        ft = 0;
        for (int k = 7; k >= 1; k--) if (!alive[k]) ft = k;
        ack = spawn_req && ft != 0;
        for (int k = 0; k < 8; k++) act[k] = alive[k];
        #1;
        chk("spawn_ack", spawn_ack, ack);
        chk("spawn_trd", spawn_trd, ack ? ft : 0);
        chk("no_free", no_free, ft == 0);
        chk("trd_active", trd_active, act);
        ii.vld = ack; ii.trd = ack ? 3'(ft) : 3'd0; ii.data = spawn_data;
        ini_q.push_back(ii);
        if (stall_vld && alive[stall_trd] && n >= rdy[stall_trd])
            rdy[stall_trd] = n + 1 + ((stall_cyc == 0) ? 1 : int'(stall_cyc));
        if (ack) begin
            alive[ft] = 1'b1;
            rdy[ft]   = n + 2;
        end
        if (kill_vld && kill_trd != 0) alive[kill_trd] = 1'b0;
        if (!pipe_stall) begin
            found = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                t = (ptr + k) % 8;
                if (!found && alive[t] && n + 1 >= rdy[t]) begin
                    found = 1'b1;
                    exp_trd = 3'(t);
                end
            end
            if (found) ptr = exp_trd;
            exp_vld = found;
        end
        ei.vld = exp_vld; ei.trd = exp_trd;
        iss_q.push_back(ei);
        n++;
    endtask

    initial begin
        iss_t ei;
        ini_t ii;
        forever begin
            @(posedge clk);
            #1;
            if (run) begin
                if (iss_q.size() == 0) begin
                    total++;
                    $display("FAIL issue_queue: got empty expected entry at %0t", $time);
                end else begin
                    ei = iss_q.pop_front();
                    chk("issue_vld", issue_vld, ei.vld);
                    chk("trd_dec", trd_dec, ei.trd);
                end
                if (ini_q.size() == 0) begin
                    total++;
                    $display("FAIL init_queue: got empty expected entry at %0t", $time);
                end else begin
                    ii = ini_q.pop_front();
                    chk("init_wb", init_wb, ii.vld);
                    if (ii.vld) begin
                        chk("new_trd_wb", new_trd_wb, ii.trd);
                        chk("init_data_wb", init_data_wb, ii.data);
                    end
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step(i < 300 ? 3 : 12);
            @(negedge clk);
        end
        do_reset();
        for (int i = 0; i < 700; i++) begin
            step(8);
            @(negedge clk);
        end
        run = 1'b0;
        chk("queues_drained", iss_q.size() + ini_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
